sidechan_ook_sched: RTL and testbench

//   On-off-keying scheduler for the shift-register aggressor. Replaces the manual button:

---
 rtl/sidechan_pkg.sv | 13 +
 rtl/sidechan_bit_timer.sv | 29 ++
 rtl/sidechan_ook_sched.sv | 131 +++++++++++++
 tb/tb_sidechan_ook_sched.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sidechan_pkg.sv
// rtl/sidechan_pkg.sv - shared FSM encoding and default preamble for the OOK side-channel scheduler
package sidechan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_GUARD    = 2'd3
    } state_t;

    localparam logic [7:0] PREAMBLE_DEFAULT = 8'hAA;

endpackage

// File: rtl/sidechan_bit_timer.sv
// rtl/sidechan_bit_timer.sv - free-running bit-period counter with clear, wrap pulse and half-period flag
module sidechan_bit_timer #(
    parameter int BIT_CYCLES = 4000000,
    parameter int CNT_W      = $clog2(BIT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic wrap,
    output logic half
);

    logic [CNT_W-1:0] cnt;

    assign wrap = (cnt == CNT_W'(BIT_CYCLES - 1));
    // Last cycle of the first half; a registered output updated here changes exactly at mid-bit.
    assign half = (cnt == CNT_W'(BIT_CYCLES / 2 - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sidechan_ook_sched.sv
// rtl/sidechan_ook_sched.sv - OOK frame scheduler driving the shift-register aggressor toggle enable
// Optional Manchester line coding of preamble/data bits: SIDECHAN_MANCHESTER_EN
module sidechan_ook_sched
    import sidechan_pkg::*;
#(
    parameter int         BIT_CYCLES    = 4000000,
    parameter int         PREAMBLE_BITS = 8,
    parameter logic [7:0] PREAMBLE      = PREAMBLE_DEFAULT,
    parameter int         GUARD_BITS    = 4,
    parameter int         CNT_W         = $clog2(BIT_CYCLES)
) (
    input  logic       main_clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       toggle_en,
    output logic       busy,
    output logic       bit_strobe
);

`ifdef SIDECHAN_MANCHESTER_EN
    localparam logic MANCH = 1'b1;
    if (BIT_CYCLES % 2 != 0) begin : g_odd_bit_cycles
        $error("BIT_CYCLES must be even when Manchester coding is enabled");
    end
`else
    localparam logic MANCH = 1'b0;
`endif

    state_t     state;
    logic [4:0] bit_idx;
    logic [7:0] shreg;
    logic       timer_clear;
    logic       timer_wrap;
    logic       timer_half;

    assign timer_clear = (state == ST_IDLE);

    sidechan_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES),
        .CNT_W      (CNT_W)
    ) u_bit_timer (
        .clk   (main_clk),
        .rst   (reset),
        .clear (timer_clear),
        .wrap  (timer_wrap),
        .half  (timer_half)
    );

    function automatic logic pre_bit(input logic [4:0] idx);
        pre_bit = PREAMBLE[3'(PREAMBLE_BITS - 1 - int'(idx))];
    endfunction

    // Both line codes start a bit at its own value; Manchester simply inverts at mid-bit.
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            toggle_en  <= 1'b0;
            busy       <= 1'b0;
            bit_strobe <= 1'b0;
            tx_ready   <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    toggle_en <= 1'b0;
                    busy      <= 1'b0;
                    tx_ready  <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        shreg      <= tx_data;
                        bit_idx    <= '0;
                        state      <= ST_PREAMBLE;
                        busy       <= 1'b1;
                        tx_ready   <= 1'b0;
                        bit_strobe <= 1'b1;
                        toggle_en  <= pre_bit(5'd0);
                    end
                end
                ST_PREAMBLE: begin
                    if (timer_wrap) begin
                        bit_strobe <= 1'b1;
                        if (bit_idx == 5'(PREAMBLE_BITS - 1)) begin
                            state     <= ST_DATA;
                            bit_idx   <= '0;
                            toggle_en <= shreg[7];
                        end else begin
                            bit_idx   <= bit_idx + 5'd1;
                            toggle_en <= pre_bit(bit_idx + 5'd1);
                        end
                    end else if (MANCH && timer_half) begin
                        toggle_en <= ~toggle_en;
                    end
                end
                ST_DATA: begin
                    if (timer_wrap) begin
                        bit_strobe <= 1'b1;
                        if (bit_idx == 5'd7) begin
                            state     <= ST_GUARD;
                            bit_idx   <= '0;
                            toggle_en <= 1'b0;
                        end else begin
                            bit_idx   <= bit_idx + 5'd1;
                            toggle_en <= shreg[~(bit_idx[2:0] + 3'd1)];
                        end
                    end else if (MANCH && timer_half) begin
                        toggle_en <= ~toggle_en;
                    end
                end
                ST_GUARD: begin
                    toggle_en <= 1'b0;
                    if (timer_wrap) begin
                        if (bit_idx == 5'(GUARD_BITS - 1)) begin
                            state    <= ST_IDLE;
                            bit_idx  <= '0;
                            busy     <= 1'b0;
                            tx_ready <= 1'b1;
                        end else begin
                            bit_strobe <= 1'b1;
                            bit_idx    <= bit_idx + 5'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sidechan_ook_sched.sv
// tb/tb_sidechan_ook_sched.sv - self-checking bench for sidechan_ook_sched against a frame-level model
module tb_sidechan_ook_sched;

    localparam int         BC    = 4;
    localparam int         PB    = 8;
    localparam int         GB    = 2;
    localparam logic [7:0] PRE   = 8'hAA;
    localparam int         FRAME = (PB + 8 + GB) * BC;
`ifdef SIDECHAN_MANCHESTER_EN
    localparam bit MANCH = 1'b1;
`else
    localparam bit MANCH = 1'b0;
`endif

    logic       main_clk = 1'b0;
    logic       reset    = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       toggle_en;
    logic       busy;
    logic       bit_strobe;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic obs_te [FRAME];

    always #5 main_clk = ~main_clk;

    sidechan_ook_sched #(
        .BIT_CYCLES    (BC),
        .PREAMBLE_BITS (PB),
        .PREAMBLE      (PRE),
        .GUARD_BITS    (GB)
    ) dut (
        .main_clk   (main_clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .toggle_en  (toggle_en),
        .busy       (busy),
        .bit_strobe (bit_strobe)
    );

    // Expected toggle_en for cycle c of a frame carrying byte b.
    function automatic logic exp_te(input logic [7:0] b, input int c);
        int         k;
        int         ph;
        logic [7:0] p;
        logic       v;
        k = c / BC;
        ph = c % BC;
        p = PRE;
        if (k >= PB + 8) return 1'b0;
        v = (k < PB) ? p[PB - 1 - k] : b[7 - (k - PB)];
        if (MANCH && ph >= BC / 2) v = ~v;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge main_clk);
        #1;
    endtask

    // Starts on frame cycle 0, ends on the first idle cycle after the frame.
    task automatic check_frame(input logic [7:0] b, input int pulse_at);
        int strobes;
        strobes = 0;
        for (int c = 0; c < FRAME; c++) begin
            check($sformatf("te[%0d] byte %0h", c, b), toggle_en, exp_te(b, c));
            check($sformatf("busy[%0d]", c), busy, 1);
            check($sformatf("tx_ready_busy[%0d]", c), tx_ready, 0);
            check($sformatf("strobe[%0d]", c), bit_strobe, (c % BC == 0));
            obs_te[c] = toggle_en;
            strobes += int'(bit_strobe);
            if (c == pulse_at) begin
                tx_valid = 1'b1;
                tx_data  = ~b;
            end else if (pulse_at >= 0 && c == pulse_at + 1) begin
                tx_valid = 1'b0;
            end
            tick();
        end
        check("strobe_count", strobes, PB + 8 + GB);
        check("busy_fall", busy, 0);
        check("tx_ready_idle", tx_ready, 1);
        check("te_idle", toggle_en, 0);
    endtask

    task automatic send(input logic [7:0] b, input bit hold);
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        if (!hold) tx_valid = 1'b0;
    endtask

    initial begin
        logic [17:0] c5_bits;
        logic [7:0]  exp80;
        logic [7:0]  rb;

        // Reset asserted from time zero, checked mid-cycle
        #12;
        check("rst_te", toggle_en, 0);
        check("rst_busy", busy, 0);
        check("rst_strobe", bit_strobe, 0);
        check("rst_tx_ready", tx_ready, 0);
        @(posedge main_clk);
        #1;
        reset = 1'b0;
        check("rel_tx_ready", tx_ready, 0);
        tick();
        check("first_edge_tx_ready", tx_ready, 1);
        check("first_edge_busy", busy, 0);

        // NRZ frame for 8'hC5
        send(8'hC5, 1'b0);
        check_frame(8'hC5, -1);
        c5_bits = 18'b10_1010_1011_0001_0100;
        for (int k = 0; k < PB + 8 + GB; k++)
            check($sformatf("c5_bit%0d", k), obs_te[k * BC], c5_bits[17 - k]);

        // Held tx_valid: second byte taken on the first idle cycle
        send(8'h01, 1'b1);
        tx_data = 8'hFF;
        check_frame(8'h01, -1);
        tick();
        check("held_accept_busy", busy, 1);
        check_frame(8'hFF, -1);
        tx_valid = 1'b0;

        // tx_valid pulsed mid-frame is ignored
        tick();
        send(8'h3C, 1'b0);
        check_frame(8'h3C, 10);
        tick();
        check("pulse_not_taken", busy, 0);

        // Data MSB and the bit after it
        send(8'h80, 1'b0);
        check_frame(8'h80, -1);
        exp80 = MANCH ? 8'b1100_0011 : 8'b1111_0000;
        for (int i = 0; i < 8; i++)
            check($sformatf("b80_c%0d", 32 + i), obs_te[32 + i], exp80[7 - i]);

        // Random bytes
        for (int r = 0; r < 4; r++) begin
            rb = 8'($urandom);
            send(rb, 1'b0);
            check_frame(rb, -1);
        end

        // Reset during data bit 3
        send(8'hFF, 1'b0);
        for (int c = 0; c < 45; c++) tick();
        check("pre_reset_te", toggle_en, exp_te(8'hFF, 45));
        check("pre_reset_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_te", toggle_en, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_tx_ready", tx_ready, 0);
        check("mid_reset_strobe", bit_strobe, 0);
        @(posedge main_clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            check($sformatf("post_reset_te[%0d]", c), toggle_en, 0);
            check($sformatf("post_reset_busy[%0d]", c), busy, 0);
            check($sformatf("post_reset_strobe[%0d]", c), bit_strobe, 0);
            check($sformatf("post_reset_ready[%0d]", c), tx_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
